// File: rtl/bin16_bcd_serial_if.sv
// rtl/bin16_bcd_serial_if.sv - operand/result handshake bundle for the serial binary-to-BCD converter
interface bin16_bcd_serial_if #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4
);
    logic [IN_W-1:0]     Bin_In;
    logic                Start;
    logic                Busy;
    logic                Done;
    logic [4*DIGITS-1:0] Bcd_Out;
    logic                Ovf;

    modport master (output Bin_In, Start, input Busy, Done, Bcd_Out, Ovf);
    modport slave  (input Bin_In, Start, output Busy, Done, Bcd_Out, Ovf);
endinterface

// File: rtl/bin16_bcd_serial.sv
// rtl/bin16_bcd_serial.sv - sequential double-dabble converter, one shift-add iteration per clock
module bin16_bcd_serial #(
    parameter int IN_W    = 16,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                  SYS_CLK,
    input  logic                  RESET,
    bin16_bcd_serial_if.slave     bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0]   LAST_ITER = CW'(IN_W - 1);
    localparam logic [IN_W-1:0] MAX_W     = IN_W'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t          state;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adj;
    logic [IN_W-1:0] operand;
    logic [CW-1:0]   iter;
    logic            ovf_lat;
    logic            busy_q;
    logic            done_q;
    logic [BW-1:0]   bcd_q;
    logic            ovf_q;

    // add-3 correction applied to every digit before the shift
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            scratch <= '0;
            operand <= '0;
            iter    <= '0;
            ovf_lat <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        // out-of-range operands saturate so the display shows all nines
                        if (bus.Bin_In > MAX_W) begin
                            operand <= MAX_W;
                            ovf_lat <= 1'b1;
                        end else begin
                            operand <= bus.Bin_In;
                            ovf_lat <= 1'b0;
                        end
                        scratch <= '0;
                        iter    <= '0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[BW-2:0], operand[IN_W-1]};
                    operand <= {operand[IN_W-2:0], 1'b0};
                    iter    <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q  <= scratch;
                    ovf_q  <= ovf_lat;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
    assign bus.Bcd_Out = bcd_q;
    assign bus.Ovf     = ovf_q;
endmodule

// File: tb/tb_bin16_bcd_serial.sv
// tb/tb_bin16_bcd_serial.sv - randomized and directed self-checking bench for bin16_bcd_serial
module tb_bin16_bcd_serial;
    logic SYS_CLK = 1'b0;
    logic RESET   = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    bin16_bcd_serial_if #(.IN_W(16), .DIGITS(4)) bus ();

    bin16_bcd_serial #(.IN_W(16), .DIGITS(4), .MAX_VAL(9999)) dut (
        .SYS_CLK (SYS_CLK),
        .RESET   (RESET),
        .bus     (bus)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // decimal digits obtained by plain division of the saturated value
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return 16'((((s / 1000) % 10) << 12) | (((s / 100) % 10) << 8) |
                   (((s / 10) % 10) << 4) | (s % 10));
    endfunction

    // one conversion; optionally re-pulses Start with another operand while busy
    task automatic do_conv(input string tag, input int v, input int poke_at, input int poke_val);
        int busy_n, done_n, lat, both;
        logic [15:0] got_bcd;
        logic        got_ovf;
        busy_n = 0; done_n = 0; lat = -1; both = 0;
        got_bcd = '0; got_ovf = 1'b0;
        @(negedge SYS_CLK);
        bus.Bin_In = 16'(v);
        bus.Start  = 1'b1;
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        bus.Start  = 1'b0;
        bus.Bin_In = 16'($urandom);
        for (int k = 0; k < 38; k++) begin
            if (k == poke_at) begin
                bus.Start  = 1'b1;
                bus.Bin_In = 16'(poke_val);
            end else if (k == poke_at + 1) begin
                bus.Start  = 1'b0;
            end
            if (bus.Busy && bus.Done) both++;
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                done_n++;
                if (lat < 0) begin
                    lat     = k;
                    got_bcd = bus.Bcd_Out;
                    got_ovf = bus.Ovf;
                end
            end
            @(negedge SYS_CLK);
        end
        check({tag, " latency"}, 32'(lat), 32'd17);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd17);
        check({tag, " done_pulses"}, 32'(done_n), 32'd1);
        check({tag, " busy_and_done"}, 32'(both), 32'd0);
        check({tag, " bcd"}, 32'(got_bcd), 32'(ref_bcd(v)));
        check({tag, " ovf"}, 32'(got_ovf), (v > 9999) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int v, mode, done_seen, last_done, stable_err, step, prev_busy, dn;
        logic [15:0] held;
        bus.Bin_In = '0;
        bus.Start  = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        check("reset busy", 32'(bus.Busy), 32'd0);
        check("reset done", 32'(bus.Done), 32'd0);
        check("reset bcd", 32'(bus.Bcd_Out), 32'd0);
        check("reset ovf", 32'(bus.Ovf), 32'd0);
        RESET = 1'b1;

        do_conv("zero", 0, -1, 0);
        do_conv("1234", 1234, -1, 0);
        do_conv("9", 9, -1, 0);
        do_conv("100", 100, -1, 0);
        do_conv("9999", 9999, -1, 0);
        do_conv("10000", 10000, -1, 0);
        do_conv("ffff", 65535, -1, 0);
        do_conv("5_after_ovf", 5, -1, 0);
        do_conv("ignored_start", 1234, 5, 4321);

        // abort mid-conversion: outputs must clear at once and no Done appears
        @(negedge SYS_CLK);
        bus.Bin_In = 16'd1234;
        bus.Start  = 1'b1;
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        bus.Start = 1'b0;
        repeat (8) @(negedge SYS_CLK);
        RESET = 1'b0;
        #1;
        check("abort busy", 32'(bus.Busy), 32'd0);
        check("abort done", 32'(bus.Done), 32'd0);
        check("abort bcd", 32'(bus.Bcd_Out), 32'd0);
        check("abort ovf", 32'(bus.Ovf), 32'd0);
        dn = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge SYS_CLK);
            if (bus.Done || bus.Busy) dn++;
        end
        RESET = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge SYS_CLK);
            if (bus.Done) dn++;
        end
        check("abort no_done", 32'(dn), 32'd0);
        do_conv("42_after_abort", 42, -1, 0);

        for (int i = 0; i < 16; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       v = int'($urandom_range(0, 65535));
                1:       v = int'($urandom_range(0, 9999));
                2:       v = int'($urandom_range(9990, 10010));
                default: v = int'($urandom_range(0, 99));
            endcase
            do_conv($sformatf("rand%0d_%0d", i, v), v, -1, 0);
        end

        // back-to-back with Start held: operand advances after each accept
        @(negedge SYS_CLK);
        bus.Bin_In = 16'd1;
        bus.Start  = 1'b1;
        step = 1; done_seen = 0; last_done = -1; stable_err = 0; prev_busy = 0;
        held = bus.Bcd_Out;
        for (int c = 0; c < 70 && done_seen < 3; c++) begin
            @(negedge SYS_CLK);
            if (bus.Busy && !prev_busy && step < 3) begin
                step++;
                bus.Bin_In = 16'(step);
            end
            prev_busy = int'(bus.Busy);
            if (bus.Done) begin
                done_seen++;
                check($sformatf("b2b bcd%0d", done_seen), 32'(bus.Bcd_Out), 32'(ref_bcd(done_seen)));
                if (last_done >= 0) check($sformatf("b2b period%0d", done_seen), 32'(c - last_done), 32'd18);
                last_done = c;
                held = bus.Bcd_Out;
            end else if (bus.Bcd_Out !== held) begin
                stable_err++;
            end
        end
        bus.Start = 1'b0;
        check("b2b done_count", 32'(done_seen), 32'd3);
        check("b2b stable", 32'(stable_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin16_bcd_serial.md
# bin16_bcd_serial

Sequential double-dabble converter that turns the 16-bit remaining-time word from the meter counter into four packed BCD digits for the seven-segment display driver. It sits between the counter and the display multiplexer. It replaces a wide combinational divide/modulo with one shift-add iteration per clock. Results are held stable between conversions so the display never sees a partial value.

## Interface
- IN_W, 16: width of the binary operand.
- DIGITS, 4: number of BCD digits produced; Bcd_Out width = 4*DIGITS.
- MAX_VAL, 9999: largest representable value; larger operands saturate.
- SYS_CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- Bin_In  input  IN_W  binary operand; sampled only on the edge that accepts Start.
- Start  input  1  conversion request; level-sensitive, accepted only in IDLE.
- Busy  output  1  high from the accept edge until the result edge.
- Done  output  1  single-cycle pulse, high in the cycle after Bcd_Out updates.
- Bcd_Out  output  4*DIGITS  packed BCD; [15:12] thousands … [3:0] units; held between conversions.
- Ovf  output  1  set when the last accepted operand exceeded MAX_VAL; updates with Bcd_Out.

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE: Busy=0.
  - On an edge with Start=1, capture the operand into the shift register. Bin_In > MAX_VAL is replaced by MAX_VAL, and the overflow flag is latched.
  - Clear the BCD scratch and the iteration counter, set Busy=1, go to SHIFT.
- SHIFT: each edge performs exactly one iteration.
  - Every scratch nibble ≥5 gets +3.
  - Then {scratch, operand} shifts left by 1.
  - Counter increments; after the IN_W-th iteration go to FINISH.
- FINISH: one edge.
  - Bcd_Out ← scratch, Ovf ← latched flag.
  - Done ← 1 for one cycle, Busy ← 0, go to IDLE.
- Start while Busy=1 is ignored; there is no queueing. Bin_In changes during a conversion have no effect.
- Start held high: a new conversion is accepted on the first IDLE edge, so conversions run back-to-back.
- Outputs other than Done/Busy change only on the FINISH edge.
- Scratch width 4*DIGITS; the iteration counter is wide enough for IN_W (5 bits at default).
- Saturated operands always produce all-nines. No nibble may ever exceed 9 on Bcd_Out.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Ovf=0, Bcd_Out=0, scratch/operand/counter=0.
- RESET low mid-conversion aborts immediately. Outputs return to reset values, no Done is emitted, and the previous Bcd_Out is lost.
- Accept edge E0 → iterations on E1..E16 → FINISH edge E17.
  - Bcd_Out/Ovf valid and Done=1 during the cycle after E17.
  - Latency = 17 clocks; Busy high for cycles E0..E17.
- Earliest next accept is E18, giving a back-to-back period of 18 clocks at defaults. In general: IN_W+2.
- Done and Busy are never high in the same cycle.
- Release of RESET: the first accept may occur on the first rising edge with RESET high.

## Test plan
- Reset release, Bin_In=0, Start pulse 1 cycle -> Busy 17 cycles; Done pulse 17 edges after accept; Bcd_Out=0x0000, Ovf=0.
- Bin_In=0x04D2 (1234) -> Bcd_Out=0x1234, Ovf=0. Then Bin_In=0x0009 -> 0x0009; Bin_In=0x0064 (100) -> 0x0100.
- Boundaries:
  - Bin_In=9999 (0x270F) -> 0x9999, Ovf=0.
  - Bin_In=10000 (0x2710) -> 0x9999, Ovf=1.
  - Bin_In=0xFFFF -> 0x9999, Ovf=1.
  - Then Bin_In=5 -> 0x0005 with Ovf cleared.
- Convert 1234, then at 5 cycles in pulse Start again and change Bin_In to 4321 -> second Start ignored; result 0x1234 with a single Done; Bin_In change has no effect.
- Start 1234, assert RESET at 8 cycles after accept for 2 cycles -> Busy/Done/Bcd_Out/Ovf all 0 immediately, no Done. Next Start with 42 -> 0x0042 at normal latency.
- Start held high, Bin_In stepping 1,2,3 each accept -> Done every 18 clocks; Bcd_Out 0x0001, 0x0002, 0x0003; Bcd_Out stable between Done pulses.
